// File: rtl/evn_trg_router.sv
// evn_trg_router: routes source triggers/events to destinations with holdoff, and collects sticky maskable interrupts
module evn_trg_router #(
    parameter int NS = 7,
    parameter int ND = 7,
    parameter int NI = 6,
    parameter int HW = 16,
    parameter int SW = $clog2(NS+1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [NS-1:0]    src_trg_i,
    input  logic [NS*4-1:0]  src_evn_i,
    input  logic [ND*SW-1:0] cfg_sel_i,
    input  logic [ND-1:0]    cfg_ena_i,
    input  logic [HW-1:0]    cfg_hld_i,
    output logic [ND-1:0]    dst_trg_o,
    output logic [ND*4-1:0]  dst_evn_o,
    input  logic [NI-1:0]    irq_i,
    input  logic [NI-1:0]    irq_msk_i,
    input  logic [NI-1:0]    irq_clr_i,
    output logic [NI-1:0]    irq_pnd_o,
    output logic             irq_o
);
    logic [NS-1:0]   trg_q;
    logic [NI-1:0]   irq_q;
    logic            rdy;
    logic [HW-1:0]   hld [ND];
    logic [HW-1:0]   hld_nx [ND];
    logic [ND-1:0]   fire;
    logic [ND*4-1:0] evn;
    logic [SW-1:0]   idx;
    logic            vld;
    logic [NS-1:0]   src_edg;
    logic [NI-1:0]   irq_rise;

    // rdy masks the first cycle after reset, so a level held high through reset is not taken as a fresh edge
    assign src_edg  = src_trg_i & ~trg_q & {NS{rdy}};
    assign irq_rise = irq_i & ~irq_q & {NI{rdy}};

    // Per-destination source select, fire decision and holdoff next state (an rst event wins over an edge)
    always_comb begin
        fire   = '0;
        evn    = '0;
        idx    = '0;
        vld    = 1'b0;
        hld_nx = '{default: '0};
        for (int d = 0; d < ND; d++) begin
            vld           = cfg_ena_i[d] && (cfg_sel_i[d*SW +: SW] < SW'(NS));
            idx           = vld ? cfg_sel_i[d*SW +: SW] : '0;
            evn[d*4 +: 4] = vld ? src_evn_i[{idx, 2'b00} +: 4] : 4'b0;
            fire[d]       = vld && src_edg[idx] && !evn[d*4] && hld[d] == '0;
            hld_nx[d]     = (!cfg_ena_i[d] || evn[d*4]) ? '0 :
                            fire[d] ? cfg_hld_i :
                            (hld[d] != '0) ? hld[d] - HW'(1) : '0;
        end
    end

    // Registered state and outputs; reset also aborts any running holdoff
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            trg_q     <= '0;
            irq_q     <= '0;
            rdy       <= 1'b0;
            hld       <= '{default: '0};
            dst_trg_o <= '0;
            dst_evn_o <= '0;
            irq_pnd_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            trg_q     <= src_trg_i;
            irq_q     <= irq_i;
            rdy       <= 1'b1;
            hld       <= hld_nx;
            dst_trg_o <= fire;
            dst_evn_o <= evn;
            irq_pnd_o <= (irq_pnd_o & ~irq_clr_i) | irq_rise;
            irq_o     <= |(irq_pnd_o & irq_msk_i);
        end
    end
endmodule

// File: tb/tb_evn_trg_router.sv
// tb_evn_trg_router: scoreboard-driven checks of routing, holdoff, gating, interrupts and reset
module tb_evn_trg_router;
    localparam int NS = 7;
    localparam int ND = 7;
    localparam int NI = 6;
    localparam int HW = 16;
    localparam int SW = 3;

    logic             clk = 1'b0;
    logic             rstn_i;
    logic [NS-1:0]    src_trg_i;
    logic [NS*4-1:0]  src_evn_i;
    logic [ND*SW-1:0] cfg_sel_i;
    logic [ND-1:0]    cfg_ena_i;
    logic [HW-1:0]    cfg_hld_i;
    logic [ND-1:0]    dst_trg_o;
    logic [ND*4-1:0]  dst_evn_o;
    logic [NI-1:0]    irq_i;
    logic [NI-1:0]    irq_msk_i;
    logic [NI-1:0]    irq_clr_i;
    logic [NI-1:0]    irq_pnd_o;
    logic             irq_o;

    int checks = 0;
    int errors = 0;

    logic [ND-1:0]   q_trg[$];
    logic [ND*4-1:0] q_evn[$];
    logic [NI:0]     q_irq[$];

    evn_trg_router #(.NS(NS), .ND(ND), .NI(NI), .HW(HW)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .src_trg_i(src_trg_i), .src_evn_i(src_evn_i),
        .cfg_sel_i(cfg_sel_i), .cfg_ena_i(cfg_ena_i), .cfg_hld_i(cfg_hld_i),
        .dst_trg_o(dst_trg_o), .dst_evn_o(dst_evn_o),
        .irq_i(irq_i), .irq_msk_i(irq_msk_i), .irq_clr_i(irq_clr_i),
        .irq_pnd_o(irq_pnd_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic route_d2(input int src);
        for (int d = 0; d < ND; d++) cfg_sel_i[d*SW +: SW] = 3'd7;
        cfg_sel_i[2*SW +: SW] = SW'(src);
        cfg_ena_i = 7'b0000100;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        src_evn_i = '1;
        step();
        step();
        checks++;
        if (dst_trg_o !== '0 || dst_evn_o !== '0 || irq_pnd_o !== '0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset trg=%b evn=%h pnd=%b irq=%b expected all 0", dst_trg_o, dst_evn_o, irq_pnd_o, irq_o);
        end
        src_evn_i = '0;
        rstn_i = 1'b1;
        step();
        step();
    endtask

    task automatic test_routing();
        logic [ND-1:0] et;
        logic [ND*4-1:0] ee;
        cfg_hld_i = '0;
        route_d2(4);
        for (int c = 0; c < 8; c++) begin
            src_trg_i[4] = (c % 2 == 0) && (c < 6);
            src_evn_i[16 +: 4] = (c == 1 || c == 2) ? 4'b1000 : 4'b0000;
            q_trg.push_back(src_trg_i[4] ? 7'b0000100 : 7'b0);
            ee = '0;
            ee[8 +: 4] = (c == 1 || c == 2) ? 4'b1000 : 4'b0000;
            q_evn.push_back(ee);
            step();
            et = q_trg.pop_front();
            ee = q_evn.pop_front();
            checks++;
            if (dst_trg_o !== et || dst_evn_o !== ee) begin
                errors++;
                $display("FAIL routing c=%0d trg=%b evn=%h expected trg=%b evn=%h", c, dst_trg_o, dst_evn_o, et, ee);
            end
        end
        src_trg_i = '0;
        src_evn_i = '0;
    endtask

    task automatic test_holdoff();
        logic [ND-1:0] et;
        logic [ND*4-1:0] ee;
        cfg_hld_i = 16'd5;
        for (int c = 0; c < 16; c++) begin
            src_trg_i[4] = (c == 0 || c == 3 || c == 6);
            q_trg.push_back((c == 0 || c == 6) ? 7'b0000100 : 7'b0);
            step();
            et = q_trg.pop_front();
            checks++;
            if (dst_trg_o !== et) begin
                errors++;
                $display("FAIL holdoff c=%0d trg=%b expected %b", c, dst_trg_o, et);
            end
        end
        for (int c = 0; c < 14; c++) begin
            src_trg_i[4] = (c == 0 || c == 3 || c == 6 || c == 9);
            src_evn_i[16] = (c == 2 || c == 6);
            q_trg.push_back((c == 0 || c == 3 || c == 9) ? 7'b0000100 : 7'b0);
            ee = '0;
            ee[8] = (c == 2 || c == 6);
            q_evn.push_back(ee);
            step();
            et = q_trg.pop_front();
            ee = q_evn.pop_front();
            checks++;
            if (dst_trg_o !== et || dst_evn_o !== ee) begin
                errors++;
                $display("FAIL holdoff_rst c=%0d trg=%b evn=%h expected trg=%b evn=%h", c, dst_trg_o, dst_evn_o, et, ee);
            end
        end
        src_trg_i = '0;
        src_evn_i = '0;
    endtask

    task automatic test_gating();
        logic [ND-1:0] et;
        logic [ND*4-1:0] ee;
        cfg_hld_i = '0;
        for (int p = 0; p < 2; p++) begin
            route_d2(p == 0 ? 7 : 4);
            if (p == 1) cfg_ena_i = '0;
            for (int c = 0; c < 4; c++) begin
                src_trg_i = (c % 2 == 0) ? '1 : '0;
                src_evn_i = (c % 2 == 0) ? '1 : '0;
                q_trg.push_back('0);
                q_evn.push_back('0);
                step();
                et = q_trg.pop_front();
                ee = q_evn.pop_front();
                checks++;
                if (dst_trg_o !== et || dst_evn_o !== ee) begin
                    errors++;
                    $display("FAIL gating p=%0d c=%0d trg=%b evn=%h expected trg=%b evn=%h", p, c, dst_trg_o, dst_evn_o, et, ee);
                end
            end
        end
        route_d2(4);
        for (int c = 0; c < 2; c++) begin
            src_evn_i[16 +: 4] = (c == 0) ? 4'b0110 : 4'b0000;
            ee = '0;
            ee[8 +: 4] = (c == 0) ? 4'b0110 : 4'b0000;
            q_evn.push_back(ee);
            step();
            ee = q_evn.pop_front();
            checks++;
            if (dst_evn_o !== ee || dst_trg_o !== '0) begin
                errors++;
                $display("FAIL gating_on c=%0d evn=%h trg=%b expected evn=%h trg=0", c, dst_evn_o, dst_trg_o, ee);
            end
        end
        src_evn_i = '0;
    endtask

    task automatic test_irq();
        logic [NI-1:0] t_irq [11] = '{6'h08, 6'h08, 6'h08, 6'h08, 6'h08, 6'h00, 6'h08, 6'h08, 6'h08, 6'h09, 6'h09};
        logic [NI-1:0] t_msk [11] = '{6'h00, 6'h00, 6'h08, 6'h08, 6'h08, 6'h08, 6'h08, 6'h08, 6'h00, 6'h01, 6'h01};
        logic [NI-1:0] t_clr [11] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00};
        logic [NI:0]   t_exp [11] = '{7'h08, 7'h08, 7'h48, 7'h40, 7'h00, 7'h00, 7'h08, 7'h48, 7'h08, 7'h09, 7'h49};
        logic [NI:0] e;
        for (int s = 0; s < 11; s++) begin
            irq_i = t_irq[s];
            irq_msk_i = t_msk[s];
            irq_clr_i = t_clr[s];
            q_irq.push_back(t_exp[s]);
            step();
            e = q_irq.pop_front();
            checks++;
            if ({irq_o, irq_pnd_o} !== e) begin
                errors++;
                $display("FAIL irq s=%0d irq_o=%b pnd=%b expected irq_o=%b pnd=%b", s, irq_o, irq_pnd_o, e[NI], e[NI-1:0]);
            end
        end
        irq_clr_i = '0;
    endtask

    task automatic test_reset_mid();
        logic [ND-1:0] et;
        logic [NI:0] e;
        cfg_hld_i = 16'd20;
        route_d2(4);
        src_trg_i[4] = 1'b1;
        step();
        checks++;
        if (dst_trg_o !== 7'b0000100) begin
            errors++;
            $display("FAIL rst_mid_fire trg=%b expected 0000100", dst_trg_o);
        end
        step();
        rstn_i = 1'b0;
        src_evn_i[16 +: 4] = 4'b1110;
        step();
        checks++;
        if (dst_trg_o !== '0 || dst_evn_o !== '0 || irq_pnd_o !== '0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid trg=%b evn=%h pnd=%b irq=%b expected all 0", dst_trg_o, dst_evn_o, irq_pnd_o, irq_o);
        end
        rstn_i = 1'b1;
        src_evn_i = '0;
        for (int c = 0; c < 5; c++) begin
            src_trg_i[4] = (c != 2);
            q_trg.push_back((c == 3) ? 7'b0000100 : 7'b0);
            q_irq.push_back('0);
            step();
            et = q_trg.pop_front();
            e = q_irq.pop_front();
            checks++;
            if (dst_trg_o !== et || {irq_o, irq_pnd_o} !== e) begin
                errors++;
                $display("FAIL rst_after c=%0d trg=%b irq=%b pnd=%b expected trg=%b irq/pnd=%b", c, dst_trg_o, irq_o, irq_pnd_o, et, e);
            end
        end
    endtask

    initial begin
        rstn_i = 1'b0;
        src_trg_i = '0;
        src_evn_i = '0;
        cfg_sel_i = '1;
        cfg_ena_i = '0;
        cfg_hld_i = '0;
        irq_i = '0;
        irq_msk_i = '0;
        irq_clr_i = '0;
        test_reset();
        test_routing();
        test_holdoff();
        test_gating();
        test_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
